// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_BIT_DEFAULT = 8;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, and keep the difference only if it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int BIT = DIV_BIT_DEFAULT
) (
  input  logic [BIT:0]   r,
  input  logic [BIT-1:0] q,
  input  logic [BIT-1:0] divisor,
  output logic [BIT:0]   r_next,
  output logic [BIT-1:0] q_next
);

  logic [BIT+1:0] r_shift;
  logic [BIT+2:0] trial;
  logic           trial_ok;

  always_comb begin
    // r stays below the divisor between steps, so the top bit carried here is
    // always zero; keeping it makes the subtraction exact at any width.
    r_shift  = {r, q[BIT-1]};
    trial    = {1'b0, r_shift} - {3'b000, divisor};
    trial_ok = ~trial[BIT+2];
    if (trial_ok) begin
      r_next = trial[BIT:0];
    end else begin
      r_next = r_shift[BIT:0];
    end
    q_next = {q[BIT-2:0], trial_ok};
  end

endmodule

// File: rtl/seq_divider_8x8.sv
// Unsigned bit-serial restoring divider with valid/ready on both sides.
// Optional macro DIVIDER_EARLY_EXIT_EN finishes divide-by-zero and dividend<divisor in one cycle.
module seq_divider_8x8
  import div_pkg::*;
#(
  parameter int BIT = DIV_BIT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BIT-1:0] dividend,
  input  logic [BIT-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BIT-1:0] quotient,
  output logic [BIT-1:0] remainder,
  output logic           div_by_zero
);

  localparam int CW = clog2(BIT + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(BIT - 1);

  div_state_t     state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [BIT:0]   r_q, r_d;
  logic [BIT-1:0] q_q, q_d;
  logic [BIT-1:0] divisor_q, divisor_d;
  logic           dbz_q, dbz_d;
  logic [BIT:0]   step_r;
  logic [BIT-1:0] step_q;

  div_step #(
    .BIT (BIT)
  ) u_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (divisor_q),
    .r_next  (step_r),
    .q_next  (step_q)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    r_d       = r_q;
    q_d       = q_q;
    divisor_d = divisor_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          divisor_d = divisor;
          dbz_d     = (divisor == '0);
          count_d   = '0;
`ifdef DIVIDER_EARLY_EXIT_EN
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = {1'b0, dividend};
            state_d = DONE;
          end else if (dividend < divisor) begin
            q_d     = '0;
            r_d     = {1'b0, dividend};
            state_d = DONE;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            state_d = BUSY;
          end
`else
          q_d     = dividend;
          r_d     = '0;
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        r_d     = step_r;
        q_d     = step_q;
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      r_q       <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      r_q       <= r_d;
      q_q       <= q_d;
      divisor_q <= divisor_d;
      dbz_q     <= dbz_d;
    end
  end

  // Quotient accumulates in place of the dividend, so the registers are the result.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q[BIT-1:0];
  assign div_by_zero = dbz_q;

endmodule
